// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: moves the operand up to STEP bit positions per
// RUN cycle and publishes result, carry and zero with a one-cycle done pulse.
module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    localparam logic [AW:0] STEP_K  = (AW+1)'(STEP);
    localparam logic [AW:0] WIDTH_K = (AW+1)'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_lat;
    logic [2:0]       op_lat;
    logic [AW-1:0]    amt_lat;
    logic [AW-1:0]    remaining;

    logic [AW:0]      k;
    logic [AW-1:0]    remaining_next;
    logic [WIDTH-1:0] stepped;
    logic [AW-1:0]    shl_index;
    logic             carry_calc;
    logic             op_legal;
    logic [AW-1:0]    amt_accept;

    assign op_legal   = (op <= OP_ROL);
    assign amt_accept = op_legal ? amt : '0;

    // One RUN cycle of movement: k never exceeds what is left to move.
    always_comb begin
        k = ({1'b0, remaining} < STEP_K) ? {1'b0, remaining} : STEP_K;
        remaining_next = remaining - k[AW-1:0];
        case (op_lat)
            OP_SHR:  stepped = acc >> k;
            OP_SHRA: stepped = $signed(acc) >>> k;
            OP_SHL:  stepped = acc << k;
            OP_ROR:  stepped = (acc >> k) | (acc << (WIDTH_K - k));
            OP_ROL:  stepped = (acc << k) | (acc >> (WIDTH_K - k));
            default: stepped = acc;
        endcase
    end

    // Carry comes from the original operand for shifts and from the final value
    // for rotates; WIDTH-amt wraps naturally in AW bits as the negated amount.
    always_comb begin
        shl_index = -amt_lat;
        case (op_lat)
            OP_SHR, OP_SHRA: carry_calc = a_lat[amt_lat - 1'b1];
            OP_SHL:          carry_calc = a_lat[shl_index];
            OP_ROR:          carry_calc = stepped[WIDTH-1];
            OP_ROL:          carry_calc = stepped[0];
            default:         carry_calc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            a_lat     <= '0;
            op_lat    <= '0;
            amt_lat   <= '0;
            remaining <= '0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= a;
                        a_lat     <= a;
                        op_lat    <= op;
                        amt_lat   <= amt_accept;
                        remaining <= amt_accept;
                        if (amt_accept == '0) begin
                            result <= a;
                            carry  <= 1'b0;
                            zero   <= (a == '0);
                            state  <= DONE;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc       <= stepped;
                    remaining <= remaining_next;
                    if (remaining_next == '0) begin
                        result <= stepped;
                        carry  <= carry_calc;
                        zero   <= (stepped == '0);
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: doc/shift_rotate_unit.md
SHIFT_ROTATE_UNIT -- requirements
Module: shift_rotate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; legal values are powers of two, 8 or more.
REQ-002 SHALL have parameter STEP, default 1, meaning maximum bit positions moved per RUN cycle; legal values are powers of two from 1 to WIDTH.
REQ-003 SHALL derive AW = clog2(WIDTH) for the amount width.
REQ-004 SHALL use one clock with a synchronous, active-high reset, on ports clk and clr.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 clr  input  1  synchronous active-high reset.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 op  input  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 pass-through.
REQ-009 a  input  WIDTH  operand.
REQ-010 amt  input  AW  shift/rotate count, 0 to WIDTH-1.
REQ-011 result  output  WIDTH  registered result; holds until next accepted start.
REQ-012 carry  output  1  registered carry-out (REQ-022).
REQ-013 zero  output  1  registered flag; 1 when result equals 0.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 Acceptance: start=1 in IDLE at edge E0 SHALL latch a, op and amt into internal registers, then go to RUN if the latched amt != 0, else to DONE.
- Unsupported op SHALL latch amt as 0.
- Changes on a, op or amt after E0 SHALL have no effect.
REQ-018 Each RUN edge SHALL move the accumulator by k = min(STEP, remaining), decrement remaining by k, and go to DONE when remaining reaches 0.
REQ-019 DONE SHALL last exactly one cycle with done=1, write result, carry and zero, then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle after edge E0 + ceil(amt/STEP); amt=0 gives done in the cycle after E0.
REQ-021 Per-op arithmetic:
- SHR SHALL zero-fill the MSBs.
- SHRA SHALL replicate a[WIDTH-1].
- SHL SHALL zero-fill the LSBs.
- ROR and ROL SHALL wrap modulo WIDTH.
- Results SHALL equal a single-step reference shift by amt.
REQ-022 carry:
- SHR/SHRA: a[amt-1].
- SHL: a[WIDTH-amt].
- ROR: result[WIDTH-1].
- ROL: result[0].
- amt=0 or pass-through: 0.
REQ-023 start while busy SHALL be ignored, neither queued nor restarted.
- start high in the DONE cycle SHALL also be ignored.
- start held high SHALL be accepted in the first IDLE cycle after DONE.
REQ-024 result, carry and zero SHALL change only in the DONE cycle and on clr.
- Between operations they SHALL hold their last values.

Reset
REQ-025 clr=1 at an edge SHALL force IDLE, clear internal registers, and set result=0, carry=0, zero=1, busy=0, done=0.
REQ-026 clr SHALL take priority over start and over any RUN or DONE activity.
- An operation interrupted by clr SHALL produce no done pulse.
- The first start after clr deasserts SHALL be accepted normally.

Verification
REQ-027 ROR, a=0xFFFFFFE0, amt=2, STEP=1 -> done 2 cycles after acceptance; result=0x3FFFFFF8, carry=0, zero=0.
REQ-028 SHRA, a=0xFFFFFFE0, amt=2 -> result=0xFFFFFFF8. SHR, a=128, amt=3 -> result=16, carry=0.
REQ-029 SHL, a=0x80000001, amt=1 -> result=0x00000002, carry=1. SHR, a=1, amt=1 -> result=0, zero=1, carry=1.
REQ-030 STEP=4, ROL, a=0x80000000, amt=31 -> done in the cycle after E0+8; result=0x40000000, carry=0. amt=0 -> done in the cycle after E0, result=a.
REQ-031 Second start with different operands pulsed mid-RUN -> ignored; first result unchanged; done pulses once.
REQ-032 clr asserted in the third RUN cycle -> IDLE next cycle, no done, result=0, zero=1; a new start is then accepted and completes correctly.
